lcd_frame_ctrl: RTL
===================

// Module: lcd_frame_ctrl
// PURPOSE
//  Sequencer that drives the byte-wide SPI transmitter for the Nokia 5110 (PCD8544) LCD.
//  After reset it pulses the transmitter/LCD reset and sends the fixed init command list.
//  On each refresh request it sends home commands (X=0, Y=0), then streams 504 frame-buffer bytes as data.
//  Sits between the frame-buffer RAM read port and the SPI transmitter (data/enable/mode/ready handshake).
// PARAMETERS
//  RESET_CYCLES  16    cycles spi_nrst held low after rst deasserts (LCD reset pulse width)
//  VOP_DEFAULT   7'h3F contrast (Vop) written by init command 0x80|VOP
//  FRAME_BYTES   504   bytes per frame (84 cols x 6 banks)
// PORTS
//  clk         in   1  system clock; also the SPI bit clock domain
//  rst         in   1  synchronous reset, active-high
//  refresh     in   1  request a full-frame transfer (level or pulse, sampled every cycle)
//  init_done   out  1  high once the init list has completed; stays high until rst
//  busy        out  1  high while the init list or a frame is in progress
//  frame_done  out  1  single-cycle pulse after the last frame byte is accepted
//  fb_addr     out  9  frame-buffer read address (0..FRAME_BYTES-1); read latency is 1 cycle
//  fb_rdata    in   8  frame-buffer read data
//  spi_nrst    out  1  active-low reset to the SPI transmitter; the transmitter forwards it to the LCD
//  spi_data    out  8  byte to transmit
//  spi_mode    out  1  1 = command, 0 = data (LCD D/C)
//  spi_enable  out  1  transmit request, 1-cycle pulse
//  spi_ready   in   1  transmitter idle
// BEHAVIOUR
//  Reset values: spi_nrst=0, spi_enable=0, spi_data=0, spi_mode=1, init_done=0, busy=1, frame_done=0, fb_addr=0.
//  FSM states: S_RST, S_INIT, S_IDLE, S_HOME, S_FETCH, S_SEND, S_WAIT_LO, S_WAIT_HI.
//  S_RST: count RESET_CYCLES with spi_nrst=0; then spi_nrst=1 and go to S_INIT with idx=0.
//  Init list (mode=1), in this order: 21, 80|VOP, 04, 14, 20, 0C (hex).
//  Byte issue (shared by all bytes):
//   - In S_SEND with spi_ready=1: spi_enable=1 for exactly 1 cycle, then go to S_WAIT_LO.
//   - S_WAIT_LO: wait for spi_ready=0. If it is not seen within 4 cycles, re-issue from S_SEND.
//   - S_WAIT_HI: wait for spi_ready=1, then advance to the next byte.
//   - spi_data and spi_mode stay stable from the enable cycle until spi_ready falls. The transmitter captures one cycle after enable.
//  After init byte 5 completes: init_done=1, go to S_IDLE.
//  S_IDLE: busy=0. A pending request or refresh=1 starts a frame via S_HOME.
//  S_HOME: send 80, then 40 (mode=1).
//  Frame phase:
//   - S_FETCH drives fb_addr=cnt for 1 cycle.
//   - S_SEND registers fb_rdata into spi_data with mode=0.
//   - cnt increments after S_WAIT_HI.
//  After byte FRAME_BYTES-1 completes: frame_done pulses; cnt wraps to 0; go to S_IDLE.
//  refresh while busy sets a 1-deep pending flag. Further requests merge into it; it clears when its frame starts.
//  refresh during init is also held pending and is serviced after init_done.
//  rst mid-transfer aborts immediately to S_RST. Pending is cleared and the LCD is re-initialised.
//  Counter widths: cnt 9b, compared against FRAME_BYTES-1 (no overflow); init idx 3b.
// CONFIGURATION
//  LCD_VOP_PORT_EN defined:
//   - Adds input vop[6:0]. It is sampled when the 80|VOP byte is loaded.
//   - Adds input vop_update. A pulse in S_IDLE sends 21, 80|vop, 20 (mode=1), then returns to S_IDLE without init_done changing.
//  LCD_VOP_PORT_EN undefined: no vop ports; VOP_DEFAULT is used; vop_update does not exist.
// STRUCTURE
//  Package lcd_pkg holds:
//   - state enum, init command constants, CMD_SET_X0=8'h80, CMD_SET_Y0=8'h40
//   - FRAME_BYTES, INIT_LEN=6
//  Sub-module lcd_init_rom (combinational): index -> {mode,byte}, including the vop byte.
// TESTING (SPI transmitter model: ready drops 1 cycle after enable, returns after 9 cycles)
//  1. Deassert rst -> spi_nrst low 16 cycles; bytes 21,BF,04,14,20,0C all mode=1; then init_done=1, busy=0.
//  2. refresh pulse in idle; fb holds addr[7:0] -> 80,40 (mode=1), then 00,01..F7 (mode=0, 504 bytes); frame_done 1 pulse.
//  3. Three refresh pulses mid-frame -> exactly one extra frame follows, then idle.
//  4. Model withholds the ready drop once -> re-issue after 4 cycles; byte sent exactly once after the model recovers.
//  5. rst asserted at byte 200 -> outputs at reset values next cycle; full init replays; no frame_done.
//  6. With LCD_VOP_PORT_EN, vop=7'h45 plus vop_update in idle -> 21,C5,20 mode=1; init_done stays 1.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared state encodings, command bytes and sizes for the PCD8544 frame sequencer.
package lcd_pkg;

   typedef enum logic [2:0] {
      S_RST, S_INIT, S_IDLE, S_HOME, S_FETCH, S_SEND, S_WAIT_LO, S_WAIT_HI
   } state_t;

   // Selects which byte source S_SEND loads and how S_WAIT_HI advances.
   typedef enum logic [1:0] {
      PH_INIT, PH_HOME, PH_FRAME, PH_VOP
   } phase_t;

   localparam logic [7:0] CMD_FUNC_EXT    = 8'h21;
   localparam logic [7:0] CMD_SET_VOP     = 8'h80;
   localparam logic [7:0] CMD_TEMP_COEF   = 8'h04;
   localparam logic [7:0] CMD_BIAS        = 8'h14;
   localparam logic [7:0] CMD_FUNC_BASIC  = 8'h20;
   localparam logic [7:0] CMD_DISP_NORMAL = 8'h0C;
   localparam logic [7:0] CMD_SET_X0      = 8'h80;
   localparam logic [7:0] CMD_SET_Y0      = 8'h40;

   localparam int FRAME_BYTES = 504;
   localparam int INIT_LEN    = 6;
   localparam int VOP_SEQ_LEN = 3;

   // The contrast update replays init entries 0, 1 and 4 (21, 80|vop, 20).
   function automatic logic [2:0] vop_seq_rom_idx(input logic [2:0] step);
      return (step == 3'd2) ? 3'd4 : step;
   endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational init command table: index -> {mode, byte}, with the live Vop folded in.
module lcd_init_rom (
   input  logic [2:0] idx,
   input  logic [6:0] vop,
   output logic [8:0] entry
);
   import lcd_pkg::*;

   always_comb begin
      entry = {1'b1, CMD_FUNC_BASIC};
      case (idx)
         3'd0:    entry = {1'b1, CMD_FUNC_EXT};
         3'd1:    entry = {1'b1, CMD_SET_VOP | {1'b0, vop}};
         3'd2:    entry = {1'b1, CMD_TEMP_COEF};
         3'd3:    entry = {1'b1, CMD_BIAS};
         3'd4:    entry = {1'b1, CMD_FUNC_BASIC};
         3'd5:    entry = {1'b1, CMD_DISP_NORMAL};
         default: entry = {1'b1, CMD_FUNC_BASIC};
      endcase
   end

endmodule

// File: rtl/lcd_frame_ctrl.sv
// Nokia 5110 sequencer: LCD reset pulse, init list, then home + 504-byte frame per refresh.
// Optional LCD_VOP_PORT_EN adds vop/vop_update for runtime contrast changes.
module lcd_frame_ctrl #(
   parameter int unsigned RESET_CYCLES = 16,
   parameter logic [6:0]  VOP_DEFAULT  = 7'h3F,
   parameter int unsigned FRAME_BYTES  = lcd_pkg::FRAME_BYTES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       refresh,
`ifdef LCD_VOP_PORT_EN
   input  logic [6:0] vop,
   input  logic       vop_update,
`endif
   output logic       init_done,
   output logic       busy,
   output logic       frame_done,
   output logic [8:0] fb_addr,
   input  logic [7:0] fb_rdata,
   output logic       spi_nrst,
   output logic [7:0] spi_data,
   output logic       spi_mode,
   output logic       spi_enable,
   input  logic       spi_ready
);
   import lcd_pkg::*;

   localparam int         RCW       = $clog2(RESET_CYCLES + 1);
   localparam logic [8:0] LAST_ADDR = 9'(FRAME_BYTES - 1);

   state_t         state, state_n;
   phase_t         phase, phase_n;
   logic [RCW-1:0] rst_cnt, rst_cnt_n;
   logic [2:0]     idx, idx_n;
   logic [8:0]     cnt, cnt_n;
   logic [1:0]     wait_cnt, wait_cnt_n;
   logic           home_sel, home_sel_n;
   logic           pending, pending_n;
   logic           init_done_n, frame_done_n, spi_nrst_n, spi_mode_n, spi_enable_n;
   logic [8:0]     fb_addr_n;
   logic [7:0]     spi_data_n;

   logic           vop_req;
   logic [6:0]     vop_val;
   logic [2:0]     rom_idx;
   logic [8:0]     rom_entry;
   logic [7:0]     byte_sel;
   logic           mode_sel;

`ifdef LCD_VOP_PORT_EN
   assign vop_req = vop_update;
   assign vop_val = vop;
`else
   assign vop_req = 1'b0;
   assign vop_val = VOP_DEFAULT;
`endif

   assign rom_idx = (phase == PH_VOP) ? vop_seq_rom_idx(idx) : idx;

   lcd_init_rom u_init_rom (
      .idx   (rom_idx),
      .vop   (vop_val),
      .entry (rom_entry)
   );

   always_comb begin
      byte_sel = rom_entry[7:0];
      mode_sel = rom_entry[8];
      case (phase)
         PH_HOME: begin
            byte_sel = home_sel ? CMD_SET_Y0 : CMD_SET_X0;
            mode_sel = 1'b1;
         end
         PH_FRAME: begin
            byte_sel = fb_rdata;
            mode_sel = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_n      = state;
      phase_n      = phase;
      rst_cnt_n    = rst_cnt;
      idx_n        = idx;
      cnt_n        = cnt;
      wait_cnt_n   = wait_cnt;
      home_sel_n   = home_sel;
      pending_n    = pending;
      init_done_n  = init_done;
      frame_done_n = 1'b0;
      fb_addr_n    = fb_addr;
      spi_nrst_n   = spi_nrst;
      spi_data_n   = spi_data;
      spi_mode_n   = spi_mode;
      spi_enable_n = 1'b0;

      if (refresh && state != S_IDLE)
         pending_n = 1'b1;

      case (state)
         S_RST: begin
            spi_nrst_n = 1'b0;
            if (rst_cnt == RCW'(RESET_CYCLES)) begin
               spi_nrst_n = 1'b1;
               idx_n      = 3'd0;
               phase_n    = PH_INIT;
               state_n    = S_INIT;
            end else begin
               rst_cnt_n = rst_cnt + RCW'(1);
            end
         end
         S_INIT:  state_n = S_SEND;
         S_IDLE: begin
            if (pending || refresh) begin
               pending_n  = 1'b0;
               home_sel_n = 1'b0;
               phase_n    = PH_HOME;
               state_n    = S_HOME;
            end else if (vop_req) begin
               idx_n   = 3'd0;
               phase_n = PH_VOP;
               state_n = S_SEND;
            end
         end
         S_HOME:  state_n = S_SEND;
         S_FETCH: state_n = S_SEND;
         // Data/mode are reloaded every cycle here so a re-issue picks up the same byte.
         S_SEND: begin
            spi_data_n = byte_sel;
            spi_mode_n = mode_sel;
            wait_cnt_n = 2'd0;
            if (spi_ready) begin
               spi_enable_n = 1'b1;
               state_n      = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            if (!spi_ready)
               state_n = S_WAIT_HI;
            else if (wait_cnt == 2'd3)
               state_n = S_SEND;
            else
               wait_cnt_n = wait_cnt + 2'd1;
         end
         S_WAIT_HI: begin
            if (spi_ready) begin
               case (phase)
                  PH_INIT: begin
                     if (idx == 3'(INIT_LEN - 1)) begin
                        init_done_n = 1'b1;
                        state_n     = S_IDLE;
                     end else begin
                        idx_n   = idx + 3'd1;
                        state_n = S_INIT;
                     end
                  end
                  PH_HOME: begin
                     if (!home_sel) begin
                        home_sel_n = 1'b1;
                        state_n    = S_HOME;
                     end else begin
                        phase_n   = PH_FRAME;
                        cnt_n     = 9'd0;
                        fb_addr_n = 9'd0;
                        state_n   = S_FETCH;
                     end
                  end
                  PH_FRAME: begin
                     if (cnt == LAST_ADDR) begin
                        cnt_n        = 9'd0;
                        frame_done_n = 1'b1;
                        state_n      = S_IDLE;
                     end else begin
                        cnt_n     = cnt + 9'd1;
                        fb_addr_n = cnt + 9'd1;
                        state_n   = S_FETCH;
                     end
                  end
                  default: begin
                     if (idx == 3'(VOP_SEQ_LEN - 1)) begin
                        state_n = S_IDLE;
                     end else begin
                        idx_n   = idx + 3'd1;
                        state_n = S_SEND;
                     end
                  end
               endcase
            end
         end
         default: state_n = S_RST;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RST;
         phase      <= PH_INIT;
         rst_cnt    <= '0;
         idx        <= 3'd0;
         cnt        <= 9'd0;
         wait_cnt   <= 2'd0;
         home_sel   <= 1'b0;
         pending    <= 1'b0;
         init_done  <= 1'b0;
         busy       <= 1'b1;
         frame_done <= 1'b0;
         fb_addr    <= 9'd0;
         spi_nrst   <= 1'b0;
         spi_data   <= 8'd0;
         spi_mode   <= 1'b1;
         spi_enable <= 1'b0;
      end else begin
         state      <= state_n;
         phase      <= phase_n;
         rst_cnt    <= rst_cnt_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         wait_cnt   <= wait_cnt_n;
         home_sel   <= home_sel_n;
         pending    <= pending_n;
         init_done  <= init_done_n;
         busy       <= (state_n != S_IDLE);
         frame_done <= frame_done_n;
         fb_addr    <= fb_addr_n;
         spi_nrst   <= spi_nrst_n;
         spi_data   <= spi_data_n;
         spi_mode   <= spi_mode_n;
         spi_enable <= spi_enable_n;
      end
   end

endmodule
